// File: rtl/scoreboard_hazard_unit_pkg.sv
// Shared constants, entry type and width helper for the decode-side register scoreboard.
package scoreboard_hazard_unit_pkg;

  function automatic int clog2(input int value);
    int width;
    width = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << width) < value) width++;
    end
    return width;
  endfunction

  localparam int SB_NUM_REGS = 32;
  localparam int SB_MAX_LAT  = 4;
  localparam int SB_REG_AW   = clog2(SB_NUM_REGS);
  localparam int SB_CNT_W    = clog2(SB_MAX_LAT + 1);

  // A latency of zero marks a variable-latency producer that stays pending until writeback.
  localparam logic [SB_CNT_W-1:0] LAT_VAR = '0;

  typedef struct packed {
    logic                pend;
    logic                is_var;
    logic [SB_CNT_W-1:0] cnt;
  } sb_entry_t;

endpackage

// File: rtl/scoreboard_hazard_unit_if.sv
// Decode/writeback bundle between the pipeline (master) and the scoreboard (slave).
interface scoreboard_hazard_unit_if #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int CNT_W    = 3
) ();
  logic [NUM_SRC-1:0]        de_src_valid;
  logic [NUM_SRC*REG_AW-1:0] de_src_addr;
  logic                      de_issue;
  logic                      de_rd_we;
  logic [REG_AW-1:0]         de_rd;
  logic [CNT_W-1:0]          de_lat;
  logic                      pipe_flush;
  logic                      wb_reg_write;
  logic [REG_AW-1:0]         wb_rd;
  logic                      de_stall;
  logic [NUM_SRC-1:0]        src_stall;
  logic [NUM_REGS-1:0]       pending_mask;

  modport master (
    output de_src_valid, de_src_addr, de_issue, de_rd_we, de_rd, de_lat,
           pipe_flush, wb_reg_write, wb_rd,
    input  de_stall, src_stall, pending_mask
  );

  modport slave (
    input  de_src_valid, de_src_addr, de_issue, de_rd_we, de_rd, de_lat,
           pipe_flush, wb_reg_write, wb_rd,
    output de_stall, src_stall, pending_mask
  );
endinterface

// File: rtl/scoreboard_hazard_unit_sb_entry.sv
// One architectural register's in-flight write state: pending flag, variable flag, countdown.
module sb_entry #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             load_var,
  input  logic [CNT_W-1:0] load_cnt,
  input  logic             restore,
  input  logic             rest_pend,
  input  logic             rest_var,
  input  logic [CNT_W-1:0] rest_cnt,
  input  logic             wb_clr,
  output logic             pend,
  output logic             is_var,
  output logic [CNT_W-1:0] cnt
);

  logic             pend_reg, pend_next;
  logic             var_reg, var_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_reg <= 1'b0;
      var_reg  <= 1'b0;
      cnt_reg  <= '0;
    end else begin
      pend_reg <= pend_next;
      var_reg  <= var_next;
      cnt_reg  <= cnt_next;
    end
  end

  // Priority: new issue, then flush rollback, then writeback clear, then countdown.
  always_comb begin
    pend_next = pend_reg;
    var_next  = var_reg;
    cnt_next  = cnt_reg;
    if (load) begin
      pend_next = 1'b1;
      var_next  = load_var;
      cnt_next  = load_cnt;
    end else if (restore) begin
      pend_next = rest_pend;
      var_next  = rest_var;
      cnt_next  = rest_cnt;
    end else if (wb_clr && var_reg) begin
      pend_next = 1'b0;
      var_next  = 1'b0;
    end else if (pend_reg && !var_reg && (cnt_reg != '0)) begin
      cnt_next  = cnt_reg - CNT_W'(1);
      pend_next = (cnt_reg != CNT_W'(1));
    end
  end

  assign pend   = pend_reg;
  assign is_var = var_reg;
  assign cnt    = cnt_reg;

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// Register scoreboard beside decode: RAW/WAW stall generation and single-issue flush rollback.
module scoreboard_hazard_unit
  import scoreboard_hazard_unit_pkg::*;
#(
  parameter int NUM_REGS   = SB_NUM_REGS,
  parameter int REG_AW     = clog2(NUM_REGS),
  parameter int NUM_SRC    = 2,
  parameter int MAX_LAT    = SB_MAX_LAT,
  parameter int FWD_WINDOW = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  scoreboard_hazard_unit_if.slave  sb
);

  localparam int CNT_W = clog2(MAX_LAT + 1);

  logic [NUM_REGS-1:0] pend_vec;
  logic [NUM_REGS-1:0] var_vec;
  logic [CNT_W-1:0]    cnt_arr [NUM_REGS];

  logic [CNT_W-1:0]    lat_sat;
  logic [NUM_SRC-1:0]  src_stall;
  logic                waw;
  logic                de_stall;
  logic                rd_is_zero;
  logic                acc;

  logic                snap_valid_reg;
  logic [REG_AW-1:0]   snap_rd_reg;
  logic                snap_pend_reg;
  logic                snap_var_reg;
  logic [CNT_W-1:0]    snap_cnt_reg;

  logic                restore_en;
  logic                rest_pend;
  logic                rest_var;
  logic [CNT_W-1:0]    rest_cnt;

  assign lat_sat = (int'(sb.de_lat) > MAX_LAT) ? CNT_W'(MAX_LAT) : sb.de_lat;

  // A result within FWD_WINDOW cycles of completion is covered by the bypass network.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    logic [REG_AW-1:0] addr;
    assign addr = sb.de_src_addr[gi*REG_AW +: REG_AW];
    assign src_stall[gi] = sb.de_src_valid[gi] && pend_vec[addr]
                         && (var_vec[addr] || (int'(cnt_arr[addr]) > FWD_WINDOW))
                         && !((ZERO_REG != 0) && (addr == '0));
  end

  assign waw = sb.de_issue && sb.de_rd_we && pend_vec[sb.de_rd]
            && (var_vec[sb.de_rd] || (lat_sat == CNT_W'(LAT_VAR)) || (lat_sat < cnt_arr[sb.de_rd]));

  assign de_stall   = sb.de_issue && ((|src_stall) || waw);
  assign rd_is_zero = (ZERO_REG != 0) && (sb.de_rd == '0);
  assign acc        = sb.de_issue && sb.de_rd_we && !de_stall && !sb.pipe_flush && !rd_is_zero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_valid_reg <= 1'b0;
      snap_rd_reg    <= '0;
      snap_pend_reg  <= 1'b0;
      snap_var_reg   <= 1'b0;
      snap_cnt_reg   <= '0;
    end else begin
      snap_valid_reg <= acc;
      if (acc) begin
        snap_rd_reg   <= sb.de_rd;
        snap_pend_reg <= pend_vec[sb.de_rd];
        snap_var_reg  <= var_vec[sb.de_rd];
        snap_cnt_reg  <= cnt_arr[sb.de_rd];
      end
    end
  end

  // Rolled-back fixed entries lose one cycle; a count that hits zero is no longer pending.
  always_comb begin
    restore_en = sb.pipe_flush && snap_valid_reg;
    rest_var   = snap_pend_reg && snap_var_reg;
    rest_cnt   = '0;
    if (snap_pend_reg && !snap_var_reg && (snap_cnt_reg != '0))
      rest_cnt = snap_cnt_reg - CNT_W'(1);
    rest_pend  = rest_var || (snap_pend_reg && (rest_cnt != '0));
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_entry
    if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
      assign pend_vec[gi] = 1'b0;
      assign var_vec[gi]  = 1'b0;
      assign cnt_arr[gi]  = '0;
    end else begin : g_live
      logic load_hit, restore_hit, wb_hit;
      assign load_hit    = acc && (sb.de_rd == REG_AW'(gi));
      assign restore_hit = restore_en && (snap_rd_reg == REG_AW'(gi));
      assign wb_hit      = sb.wb_reg_write && (sb.wb_rd == REG_AW'(gi));

      sb_entry #(.CNT_W(CNT_W)) u_entry (
        .clk       (clk),
        .reset     (reset),
        .load      (load_hit),
        .load_var  (lat_sat == CNT_W'(LAT_VAR)),
        .load_cnt  (lat_sat),
        .restore   (restore_hit),
        .rest_pend (rest_pend),
        .rest_var  (rest_var),
        .rest_cnt  (rest_cnt),
        .wb_clr    (wb_hit),
        .pend      (pend_vec[gi]),
        .is_var    (var_vec[gi]),
        .cnt       (cnt_arr[gi])
      );
    end
  end

  assign sb.de_stall     = de_stall;
  assign sb.src_stall    = src_stall;
  assign sb.pending_mask = pend_vec;

  a_lat_legal : assert property (@(posedge clk) disable iff (reset)
    (sb.de_issue && sb.de_rd_we) |-> (int'(sb.de_lat) <= MAX_LAT));

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Directed hazard scenarios plus random traffic, checked against a remaining-cycles model.
module tb_scoreboard_hazard_unit;

  localparam int NR  = 32;
  localparam int AW  = 5;
  localparam int NS  = 2;
  localparam int ML  = 4;
  localparam int FWD = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  scoreboard_hazard_unit_if #(.NUM_REGS(NR), .REG_AW(AW), .NUM_SRC(NS), .CNT_W(3)) sbi ();

  scoreboard_hazard_unit dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sbi)
  );

  int checks = 0;
  int errors = 0;

  // rem[r]: 0 = idle, -1 = waiting for writeback, n > 0 = cycles until the result exists.
  int rem [NR];
  bit snap_v;
  int snap_rd;
  int snap_rem;

  logic          last_stall;
  logic [NR-1:0] last_mask;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int src_addr(input int i);
    return int'(sbi.de_src_addr[i*AW +: AW]);
  endfunction

  function automatic bit m_src(input int i);
    int a;
    a = src_addr(i);
    return sbi.de_src_valid[i] && (a != 0) && (rem[a] < 0 || rem[a] > FWD);
  endfunction

  function automatic bit m_waw();
    int rd;
    int lat;
    rd  = int'(sbi.de_rd);
    lat = int'(sbi.de_lat);
    return sbi.de_issue && sbi.de_rd_we && (rem[rd] != 0)
        && (rem[rd] < 0 || lat == 0 || lat < rem[rd]);
  endfunction

  function automatic bit m_stall();
    return sbi.de_issue && (m_src(0) || m_src(1) || m_waw());
  endfunction

  function automatic logic [NR-1:0] m_mask();
    logic [NR-1:0] m;
    for (int r = 0; r < NR; r++) m[r] = (rem[r] != 0);
    return m;
  endfunction

  task automatic m_edge();
    int  nxt [NR];
    bit  acc;
    int  rd;
    int  lat;
    int  wr;
    rd  = int'(sbi.de_rd);
    lat = int'(sbi.de_lat);
    wr  = int'(sbi.wb_rd);
    acc = sbi.de_issue && sbi.de_rd_we && !m_stall() && !sbi.pipe_flush && (rd != 0);
    for (int r = 0; r < NR; r++) nxt[r] = (rem[r] > 0) ? rem[r] - 1 : rem[r];
    if (sbi.wb_reg_write && rem[wr] < 0) nxt[wr] = 0;
    if (sbi.pipe_flush && snap_v) nxt[snap_rd] = (snap_rem > 0) ? snap_rem - 1 : snap_rem;
    if (acc) nxt[rd] = (lat == 0) ? -1 : lat;
    if (acc) begin
      snap_rd  = rd;
      snap_rem = rem[rd];
    end
    snap_v = acc;
    rem = nxt;
  endtask

  task automatic m_reset();
    for (int r = 0; r < NR; r++) rem[r] = 0;
    snap_v = 1'b0;
  endtask

  task automatic step(input string tag);
    #1;
    last_stall = sbi.de_stall;
    last_mask  = sbi.pending_mask;
    check({tag, "_stall"}, 64'(sbi.de_stall), 64'(m_stall()));
    check({tag, "_src"}, 64'(sbi.src_stall), 64'({m_src(1), m_src(0)}));
    check({tag, "_mask"}, 64'(sbi.pending_mask), 64'(m_mask()));
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    sbi.de_src_valid = '0;
    sbi.de_src_addr  = '0;
    sbi.de_issue     = 1'b0;
    sbi.de_rd_we     = 1'b0;
    sbi.de_rd        = '0;
    sbi.de_lat       = '0;
    sbi.pipe_flush   = 1'b0;
    sbi.wb_reg_write = 1'b0;
    sbi.wb_rd        = '0;
  endtask

  task automatic rd_issue(input int rd, input int lat);
    sbi.de_issue = 1'b1;
    sbi.de_rd_we = 1'b1;
    sbi.de_rd    = AW'(rd);
    sbi.de_lat   = 3'(lat);
  endtask

  task automatic read_src0(input int a);
    sbi.de_issue     = 1'b1;
    sbi.de_src_valid = 2'b01;
    sbi.de_src_addr  = {5'd0, AW'(a)};
  endtask

  initial begin
    int n;
    m_reset();
    idle();
    repeat (2) @(negedge clk);
    #1;
    check("reset_mask", 64'(sbi.pending_mask), 64'd0);
    check("reset_stall", 64'(sbi.de_stall), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // RAW on a fixed 3-cycle producer: stall while more than FWD cycles remain.
    idle(); rd_issue(5, 3); step("raw_iss");
    idle(); read_src0(5);
    n = 0;
    repeat (5) begin step("raw_rd"); if (last_stall) n++; end
    check("raw_cycles", 64'(n), 64'd2);

    // Variable latency holds until writeback of that register.
    idle(); rd_issue(7, 0); step("var_iss");
    idle(); read_src0(7);
    n = 0;
    repeat (6) begin step("var_rd"); if (last_stall) n++; end
    check("var_hold", 64'(n), 64'd6);
    sbi.wb_reg_write = 1'b1; sbi.wb_rd = 5'd7; step("var_wb");
    sbi.wb_reg_write = 1'b0; step("var_after");
    check("var_release", 64'(last_stall), 64'd0);

    // WAW: same latency re-issue goes through, a shorter one waits for cnt <= 1.
    idle(); rd_issue(9, 4); step("waw_iss");
    step("waw_same");
    check("waw_same_lat", 64'(last_stall), 64'd0);
    rd_issue(9, 1);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      step("waw_short");
      if (!last_stall) break;
      n++;
    end
    check("waw_cycles", 64'(n), 64'd3);
    idle(); repeat (2) step("drain");

    // Flush rolls back the x3 issue and blocks the concurrent x4 issue.
    idle(); rd_issue(3, 2); step("fl_iss");
    rd_issue(4, 2); sbi.pipe_flush = 1'b1; step("fl_flush");
    idle(); step("fl_after");
    check("fl_x3", 64'(last_mask[3]), 64'd0);
    check("fl_x4", 64'(last_mask[4]), 64'd0);

    // x0 is hardwired.
    idle(); rd_issue(0, 3); step("x0_iss");
    idle(); step("x0_after");
    check("x0_pend", 64'(last_mask[0]), 64'd0);

    // Writeback on a variable x8 alongside a new x8 issue; retry lands as fixed lat 2.
    idle(); rd_issue(8, 0); step("pri_var");
    rd_issue(8, 2); sbi.wb_reg_write = 1'b1; sbi.wb_rd = 5'd8; step("pri_wb");
    check("pri_waw", 64'(last_stall), 64'd1);
    sbi.wb_reg_write = 1'b0; step("pri_acc");
    check("pri_acc_ok", 64'(last_stall), 64'd0);
    idle(); read_src0(8);
    n = 0;
    repeat (3) begin step("pri_rd"); if (last_stall) n++; end
    check("pri_cnt2", 64'(n), 64'd1);

    // Asynchronous reset with x5 pending and a dependent read stalled.
    idle(); rd_issue(5, 4); step("rst_iss");
    idle(); read_src0(5);
    #2;
    check("rst_pre", 64'(sbi.de_stall), 64'd1);
    reset = 1'b1;
    #1;
    check("rst_mask", 64'(sbi.pending_mask), 64'd0);
    check("rst_stall", 64'(sbi.de_stall), 64'd0);
    m_reset();
    @(negedge clk);
    reset = 1'b0;
    idle();
    @(negedge clk);

    // Random traffic concentrated on a few registers to provoke hazards.
    repeat (2000) begin
      sbi.de_issue     = ($urandom_range(0, 3) != 0);
      sbi.de_rd_we     = ($urandom_range(0, 3) != 0);
      sbi.de_rd        = AW'($urandom_range(0, 11));
      sbi.de_lat       = 3'($urandom_range(0, ML));
      sbi.de_src_valid = 2'($urandom_range(0, 3));
      sbi.de_src_addr  = {AW'($urandom_range(0, 11)), AW'($urandom_range(0, 11))};
      sbi.pipe_flush   = ($urandom_range(0, 9) == 0);
      sbi.wb_reg_write = ($urandom_range(0, 2) == 0);
      sbi.wb_rd        = AW'($urandom_range(0, 11));
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
